fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_queue.sv | 111 +++++++++++
 rtl/fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_fetch_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch controller.
//   fetch_state_e : fetch FSM states (RUN, DRAIN, DONE)
//   fq_entry_t    : one fetch-queue entry {pc, instr}
//   FQ_DEPTH / MEM_SIZE / RESET_PC : default configuration
package fetch_pkg;

   localparam int unsigned PC_W     = 64;
   localparam int unsigned INSTR_W  = 32;

   localparam int unsigned FQ_DEPTH = 4;
   localparam int unsigned MEM_SIZE = 1024;
   localparam logic [63:0] RESET_PC = 64'h0;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch queue with synchronous flush.
//   clk, rst_n         : clock, async active-low reset
//   push, push_data    : enqueue at tail (accepted when not full or popping)
//   pop                : dequeue head (ignored when empty)
//   flush              : discard all entries, wins over push/pop
//   full, empty, count : occupancy status
//   head_valid, head   : registered copy of the head entry (zero when empty)
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  fq_entry_t              push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   head_valid,
   output fq_entry_t              head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fq_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd;
   logic [PTR_W-1:0] r_wr;
   logic [CNT_W-1:0] r_count;
   logic             r_full;
   logic             r_empty;
   logic             r_head_valid;
   fq_entry_t        r_head;

   logic             w_push_ok;
   logic             w_pop_ok;
   logic [PTR_W-1:0] w_rd_next;
   logic [CNT_W-1:0] w_count_nxt;
   fq_entry_t        w_head_nxt;

   // A push into a full queue is only legal when the head leaves the same cycle.
   assign w_push_ok = push & (~r_full | pop) & ~flush;
   assign w_pop_ok  = pop & ~r_empty & ~flush;
   assign w_rd_next = r_rd + PTR_W'(1);

   // Next occupancy and next head entry, so the head can be held in a register.
   always_comb begin
      w_count_nxt = r_count;
      w_head_nxt  = r_head;
      if (flush) begin
         w_count_nxt = '0;
         w_head_nxt  = '0;
      end else begin
         case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
         endcase

         if (w_pop_ok) begin
            if (r_count == CNT_W'(1))
               w_head_nxt = w_push_ok ? push_data : '0;
            else
               w_head_nxt = r_mem[w_rd_next];
         end else if (r_empty && w_push_ok) begin
            w_head_nxt = push_data;
         end
      end
   end

   // Pointers, occupancy and head register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd         <= '0;
         r_wr         <= '0;
         r_count      <= '0;
         r_full       <= 1'b0;
         r_empty      <= 1'b1;
         r_head_valid <= 1'b0;
         r_head       <= '0;
      end else begin
         if (flush) begin
            r_rd <= '0;
            r_wr <= '0;
         end else begin
            if (w_push_ok) r_wr <= r_wr + PTR_W'(1);
            if (w_pop_ok)  r_rd <= w_rd_next;
         end
         r_count      <= w_count_nxt;
         r_full       <= (w_count_nxt == CNT_W'(DEPTH));
         r_empty      <= (w_count_nxt == '0);
         r_head_valid <= (w_count_nxt != '0);
         r_head       <= w_head_nxt;
      end
   end

   // Storage array; entries are only read after being written.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr] <= push_data;
   end

   assign full       = r_full;
   assign empty      = r_empty;
   assign count      = r_count;
   assign head_valid = r_head_valid;
   assign head       = r_head;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC register, RUN/DRAIN/DONE FSM and a
// fetch queue feeding decode.
//   clk, reset_n            : clock, async active-low reset
//   imem_addr / imem_instr  : instruction ROM address and same-cycle data
//   out_valid/ready/pc/instr: decode handshake on the queue head
//   redirect, redirect_pc   : back-end flush and new fetch address
//   misalign_err            : pulse after a redirect with redirect_pc[1:0] != 0
//   fq_count                : queue occupancy
//   done                    : end of memory reached and queue drained
module fetch_ctrl #(
   parameter int unsigned FQ_DEPTH = fetch_pkg::FQ_DEPTH,
   parameter int unsigned MEM_SIZE = fetch_pkg::MEM_SIZE,
   parameter logic [63:0] RESET_PC = fetch_pkg::RESET_PC
) (
   input  logic                      clk,
   input  logic                      reset_n,
   output logic [63:0]               imem_addr,
   input  logic [31:0]               imem_instr,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [63:0]               out_pc,
   output logic [31:0]               out_instr,
   input  logic                      redirect,
   input  logic [63:0]               redirect_pc,
   output logic                      misalign_err,
   output logic [$clog2(FQ_DEPTH):0] fq_count,
   output logic                      done
);

   import fetch_pkg::*;

   localparam int unsigned CNT_W   = $clog2(FQ_DEPTH) + 1;
   // Highest PC whose full word lies inside memory; comparing against it
   // avoids the pc+3 overflow for PCs near 2^64.
   localparam logic [63:0] LAST_PC = 64'(MEM_SIZE) - 64'd4;

   fetch_state_e     r_state;
   fetch_state_e     w_state_nxt;
   logic [63:0]      r_pc;
   logic [63:0]      w_pc_nxt;
   logic             r_misalign;
   logic             r_done;

   logic             w_push;
   logic             w_pop;
   logic             w_in_bounds;
   logic             w_full;
   logic             w_empty;
   logic [CNT_W-1:0] w_count;
   logic             w_head_valid;
   fq_entry_t        w_head;
   fq_entry_t        w_push_data;

   assign w_in_bounds = (r_pc <= LAST_PC);
   // Redirect suppresses the pop; the queue is flushed instead.
   assign w_pop       = w_head_valid & out_ready & ~redirect;
   assign w_push_data = '{pc: r_pc, instr: imem_instr};

   // Next-state, next-PC and push decision.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_push      = 1'b0;
      if (redirect) begin
         w_state_nxt = ST_RUN;
         w_pc_nxt    = {redirect_pc[63:2], 2'b00};
      end else begin
         case (r_state)
            ST_RUN: begin
               if (!w_in_bounds) begin
                  w_state_nxt = ST_DRAIN;
               end else if (!w_full || w_pop) begin
                  w_push   = 1'b1;
                  w_pc_nxt = r_pc + 64'd4;
               end
            end
            ST_DRAIN: begin
               // Enter DONE on the edge where the queue becomes empty.
               if (w_empty || (w_count == CNT_W'(1) && w_pop))
                  w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
               w_state_nxt = ST_DONE;
            end
            default: begin
               w_state_nxt = ST_RUN;
            end
         endcase
      end
   end

   // State, PC and status registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_RUN;
         r_pc       <= RESET_PC;
         r_misalign <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_misalign <= redirect & (redirect_pc[1:0] != 2'b00);
         r_done     <= (w_state_nxt == ST_DONE);
      end
   end

   fetch_queue #(
      .DEPTH (FQ_DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst_n      (reset_n),
      .push       (w_push),
      .push_data  (w_push_data),
      .pop        (w_pop),
      .flush      (redirect),
      .full       (w_full),
      .empty      (w_empty),
      .count      (w_count),
      .head_valid (w_head_valid),
      .head       (w_head)
   );

   assign imem_addr    = r_pc;
   assign out_valid    = w_head_valid;
   assign out_pc       = w_head.pc;
   assign out_instr    = w_head.instr;
   assign fq_count     = w_count;
   assign misalign_err = r_misalign;
   assign done         = r_done;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fetch_ctrl;

   import fetch_pkg::*;

   localparam int unsigned TB_FQD = 4;
   localparam int unsigned TB_MEM = 1024;
   localparam logic [63:0] TB_RST = 64'h0;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        misalign_err;
   logic [2:0]  fq_count;
   logic        done;

   int n_chk  = 0;
   int n_pass = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   // ROM contents: 0xA5000000 | 3*word_index; poison outside memory.
   function automatic logic [31:0] rom_word(input logic [63:0] a);
      if (a < 64'(TB_MEM)) return 32'hA500_0000 | 32'(a[31:2] * 30'd3);
      return 32'hDEAD_BEEF;
   endfunction

   assign imem_instr = rom_word(imem_addr);

   fetch_ctrl #(
      .FQ_DEPTH (TB_FQD),
      .MEM_SIZE (TB_MEM),
      .RESET_PC (TB_RST)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .imem_addr    (imem_addr),
      .imem_instr   (imem_instr),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_instr    (out_instr),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .misalign_err (misalign_err),
      .fq_count     (fq_count),
      .done         (done)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: a queue of {pc, instr}, a fetch address and a phase
   // (0 = fetching, 1 = draining, 2 = finished).
   fq_entry_t   mq[$];
   logic [63:0] mpc   = TB_RST;
   int          mph   = 0;
   bit          mmis  = 1'b0;
   bit          m_pop, m_push, m_inb;
   fq_entry_t   m_e;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         mpc  = TB_RST;
         mph  = 0;
         mmis = 1'b0;
      end else if (redirect) begin
         mq.delete();
         mpc  = {redirect_pc[63:2], 2'b00};
         mph  = 0;
         mmis = (redirect_pc[1:0] != 2'b00);
      end else begin
         mmis   = 1'b0;
         m_inb  = (mpc < 64'(TB_MEM)) && ((64'(TB_MEM) - mpc) >= 64'd4);
         m_pop  = (mq.size() > 0) && out_ready;
         m_push = (mph == 0) && m_inb && ((mq.size() < TB_FQD) || m_pop);
         m_e.pc    = mpc;
         m_e.instr = rom_word(mpc);
         if (m_pop) void'(mq.pop_front());
         if (m_push) begin
            mq.push_back(m_e);
            mpc = mpc + 64'd4;
         end
         if (mph == 0 && !m_inb)          mph = 1;
         else if (mph == 1 && mq.size() == 0) mph = 2;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("m_valid", 64'(out_valid), 64'(mq.size() > 0));
         check("m_count", 64'(fq_count), 64'(mq.size()));
         if (mq.size() > 0) begin
            check("m_pc",    out_pc,          mq[0].pc);
            check("m_instr", 64'(out_instr),  64'(mq[0].instr));
         end else begin
            check("m_pc0",    out_pc,         64'h0);
            check("m_instr0", 64'(out_instr), 64'h0);
         end
         check("m_addr",   imem_addr,          mpc);
         check("m_mis",    64'(misalign_err),  64'(mmis));
         check("m_done",   64'(done),          64'(mph == 2));
         check("m_xinstr", 64'($isunknown(out_instr)), 64'h0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n     = 1'b0;
      out_ready   = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 64'h0;
      tick();
      cmp_en = 1'b1;
      tick();

      // Reset state
      check("rst_valid", 64'(out_valid),    64'h0);
      check("rst_count", 64'(fq_count),     64'h0);
      check("rst_pc",    out_pc,            64'h0);
      check("rst_addr",  imem_addr,         64'h0);
      check("rst_done",  64'(done),         64'h0);
      check("rst_mis",   64'(misalign_err), 64'h0);

      // Streaming with decode always ready
      out_ready = 1'b1;
      reset_n   = 1'b1;
      tick();
      check("s_pc0",    out_pc,         64'h0);
      check("s_in0",    64'(out_instr), 64'hA500_0000);
      tick();
      check("s_pc1",    out_pc,         64'h4);
      check("s_in1",    64'(out_instr), 64'hA500_0003);
      tick();
      check("s_pc2",    out_pc,         64'h8);
      check("s_in2",    64'(out_instr), 64'hA500_0006);
      check("s_cnt",    64'(fq_count),  64'h1);

      // Back-pressure: saturate, then drain in order while refilling
      out_ready = 1'b0;
      do_reset();
      repeat (10) tick();
      check("bp_cnt",  64'(fq_count), 64'h4);
      check("bp_addr", imem_addr,     64'h10);
      check("bp_pc0",  out_pc,        64'h0);
      out_ready = 1'b1;
      tick();
      check("bp_pc1",  out_pc,        64'h4);
      check("bp_full", 64'(fq_count), 64'h4);
      tick();
      check("bp_pc2",  out_pc,        64'h8);
      tick();
      check("bp_pc3",  out_pc,        64'hC);

      // Redirect with three entries queued
      out_ready = 1'b0;
      do_reset();
      repeat (3) tick();
      check("rd_cnt3", 64'(fq_count), 64'h3);
      redirect    = 1'b1;
      redirect_pc = 64'h40;
      tick();
      redirect = 1'b0;
      check("rd_valid", 64'(out_valid), 64'h0);
      check("rd_cnt",   64'(fq_count),  64'h0);
      check("rd_addr",  imem_addr,      64'h40);
      tick();
      check("rd_v1",    64'(out_valid), 64'h1);
      check("rd_pc",    out_pc,         64'h40);
      check("rd_in",    64'(out_instr), 64'hA500_0030);

      // Misaligned redirect concurrent with a would-be pop
      out_ready   = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 64'h42;
      tick();
      redirect = 1'b0;
      check("ma_pulse", 64'(misalign_err), 64'h1);
      check("ma_cnt",   64'(fq_count),     64'h0);
      check("ma_addr",  imem_addr,         64'h40);
      tick();
      check("ma_clr",   64'(misalign_err), 64'h0);
      check("ma_pc",    out_pc,            64'h40);

      // Run off the end of memory
      redirect    = 1'b1;
      redirect_pc = 64'h3F8;
      tick();
      redirect = 1'b0;
      tick();
      check("end_pc0",  out_pc,         64'h3F8);
      tick();
      check("end_pc1",  out_pc,         64'h3FC);
      check("end_in1",  64'(out_instr), 64'hA500_02FD);
      tick();
      check("end_emp",  64'(out_valid), 64'h0);
      check("end_nd",   64'(done),      64'h0);
      tick();
      check("end_done", 64'(done),      64'h1);
      check("end_addr", imem_addr,      64'h400);
      repeat (3) tick();
      check("end_hold", 64'(done),      64'h1);
      redirect    = 1'b1;
      redirect_pc = 64'h10;
      tick();
      redirect = 1'b0;
      check("end_rst",  64'(done),      64'h0);
      check("end_raddr", imem_addr,     64'h10);

      // Asynchronous reset while full
      out_ready = 1'b0;
      do_reset();
      repeat (6) tick();
      check("ar_full",  64'(fq_count),  64'h4);
      reset_n = 1'b0;
      #1;
      check("ar_valid", 64'(out_valid), 64'h0);
      check("ar_cnt",   64'(fq_count),  64'h0);
      check("ar_addr",  imem_addr,      TB_RST);
      tick();
      reset_n = 1'b1;
      tick();
      check("ar_v1",    64'(out_valid), 64'h1);
      check("ar_pc",    out_pc,         TB_RST);
      check("ar_addr1", imem_addr,      TB_RST + 64'd4);

      tick();
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
